scan_index_gen: RTL and testbench
=================================

# scan_index_gen

Programmable step sequencer that produces the 3-bit select index consumed by the team's 3-to-8 one-hot decoder. It is used for display-digit scanning and row strobing. A prescaler divides the system clock into step ticks. The block supports up, down and (optionally) ping-pong stepping, plus synchronous preload. Step and wrap pulses let downstream logic latch per-digit data.

## Interface
- DIV, default 4: clock cycles per step; legal range 1..65535; prescaler width = $clog2(DIV), minimum 1 bit.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; when low, the prescaler and index hold.
- dir  in  1  direction: 0 = up, 1 = down.
- load  in  1  synchronous preload strobe.
- load_val  in  3  preload value for sel.
- pp  in  1  ping-pong mode select; ignored unless SCAN_PINGPONG_EN is defined.
- sel  out  3  registered index feeding the decoder input.
- tick  out  1  one-cycle pulse in the first cycle that sel shows a new stepped value.
- wrap  out  1  one-cycle pulse coincident with tick when the step wraps (up 7→0, down 0→7) or reverses (ping-pong).

## Operation
- Reset (rst_n=0, asynchronous): sel=0, tick=0, wrap=0, prescaler=0, internal ping-pong direction pdir=0 (up).
- Priority per edge: load > step > hold.
- Load:
  - sel←load_val; prescaler←0; pdir←dir.
  - tick=0 and wrap=0 next cycle.
  - Load is honoured regardless of en.
- Prescaler:
  - When en=1 and load=0, it counts 0..DIV-1.
  - A step occurs on the edge where the count is DIV-1; the count returns to 0 on that edge.
  - When en=0, the count holds.
- Step, normal mode:
  - sel←sel+1 (dir=0) or sel−1 (dir=1), modulo 8.
  - wrap=1 when sel goes 7→0 (up) or 0→7 (down).
- Step, ping-pong mode (macro defined and pp=1):
  - Direction comes from pdir, not dir.
  - At sel=7 with pdir=up: sel←6, pdir←down, wrap=1.
  - At sel=0 with pdir=down: sel←1, pdir←up, wrap=1.
  - Otherwise sel steps per pdir.
- tick and wrap are registered and are 0 in every cycle not immediately following a step.
- A change of dir mid-count takes effect at the next step; the prescaler is not reset.
- A change of pp mid-count takes effect at the next step; the prescaler is not reset.
- Leaving ping-pong mode: pdir retains its value, and dir governs from then on.

## Timing
- sel, tick and wrap are flops with no combinational input-to-output paths.
- Step latency:
  - With en held high after reset or load, the first step is visible DIV cycles after the first enabled edge.
  - Subsequent steps follow every DIV enabled cycles.
- DIV=1: sel steps every enabled cycle, and tick is high continuously while en=1.
- Load latency: sel=load_val in the cycle after the load edge.
- en deasserted on the step edge: the step does not occur, and the prescaler stays at DIV-1. The step fires on the first edge at which en returns high.
- Reset asserted mid-count: all outputs go to their reset values immediately, independent of clk.
- Reset release: counting starts at the first rising edge with rst_n=1 and en=1.

## Configuration
- SCAN_PINGPONG_EN defined:
  - The pp input and pdir register are implemented.
  - Reversal behaviour is as described under Operation.
- SCAN_PINGPONG_EN undefined:
  - pp is accepted but ignored, and no pdir register exists.
  - The block always steps per dir with modulo-8 wrap.

## Test plan
- Reset mid-run: with DIV=4 and en=1, pulse rst_n low between edges → sel=0, tick=0, wrap=0 immediately. After release, first tick on the 4th enabled edge with sel=1.
- Up wrap: DIV=2, dir=0, en=1 from sel=0 → sel sequence 1..7,0 every 2 cycles. Eight tick pulses total; wrap pulses only with the 7→0 step.
- Down and load: load_val=2, load=1 for one cycle, then dir=1, en=1, DIV=1 → sel=2,1,0,7,6. tick high each stepped cycle; wrap high only at the 0→7 step.
- Enable gating: DIV=3 with en dropped for 5 cycles while the prescaler is at 2 → no step during the gap. Step occurs on the first edge after en returns.
- Load vs step collision: load=1, load_val=5 on a step edge → sel=5 next cycle, tick=0, and the next step comes DIV enabled cycles later.
- Ping-pong (macro defined): DIV=1, pp=1, load_val=5 with dir=0 → sel=6,7,6,5,…,1,0,1. wrap pulses at the 7→6 and 0→1 reversals.

Source files
------------

// File: rtl/scan_index_gen.sv
// 3-bit scan index sequencer (up/down, optional ping-pong via SCAN_PINGPONG_EN) with prescaled step ticks.
// Latency: first step visible DIV enabled cycles after reset/load; load visible next cycle.
// Backpressure: none; en low freezes prescaler and index, load always wins.
module scan_index_gen #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       pp,
    output logic [2:0] sel,
    output logic       tick,
    output logic       wrap
);

    localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;
    logic [2:0]    step_sel;
    logic          step_wrap;

`ifdef SCAN_PINGPONG_EN
    logic pdir;
    logic step_pdir;
`else
    wire unused_pp = pp;
`endif

    // Next index if a step happens this edge; applied only when the prescaler expires.
    always_comb begin
        step_sel  = dir ? (sel - 3'd1) : (sel + 3'd1);
        step_wrap = dir ? (sel == 3'd0) : (sel == 3'd7);
`ifdef SCAN_PINGPONG_EN
        step_pdir = pdir;
        if (pp) begin
            if (!pdir && (sel == 3'd7)) begin
                step_sel  = 3'd6;
                step_wrap = 1'b1;
                step_pdir = 1'b1;
            end else if (pdir && (sel == 3'd0)) begin
                step_sel  = 3'd1;
                step_wrap = 1'b1;
                step_pdir = 1'b0;
            end else begin
                step_sel  = pdir ? (sel - 3'd1) : (sel + 3'd1);
                step_wrap = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sel  <= 3'd0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            cnt  <= '0;
            sel  <= load_val;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                sel  <= step_sel;
                tick <= 1'b1;
                wrap <= step_wrap;
            end else begin
                cnt  <= cnt + PW'(1);
                tick <= 1'b0;
                wrap <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

`ifdef SCAN_PINGPONG_EN
    // pdir only moves on load or on a ping-pong step; it is retained when pp drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdir <= 1'b0;
        end else if (load) begin
            pdir <= dir;
        end else if (en && (cnt == LAST)) begin
            pdir <= step_pdir;
        end
    end
`endif

endmodule

// File: tb/tb_scan_index_gen.sv
// Scoreboard bench for scan_index_gen: five instances (DIV 1,2,3,4,7) share one randomized stimulus stream.
module tb_scan_index_gen;

    localparam int NI = 5;
`ifdef SCAN_PINGPONG_EN
    localparam bit PPEN = 1'b1;
`else
    localparam bit PPEN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] sel;
        logic       tick;
        logic       wrap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic       pp = 1'b0;

    logic [2:0] sel_o  [NI];
    logic       tick_o [NI];
    logic       wrap_o [NI];

    exp_t q [NI][$];
    int   m_sel  [NI];
    int   m_cnt  [NI];
    bit   m_pdir [NI];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic int div_of(input int i);
        return (i == 4) ? 7 : i + 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D = (g == 4) ? 7 : g + 1;
        scan_index_gen #(.DIV(D)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .dir      (dir),
            .load     (load),
            .load_val (load_val),
            .pp       (pp),
            .sel      (sel_o[g]),
            .tick     (tick_o[g]),
            .wrap     (wrap_o[g])
        );
    end

    // Reference model: count enabled cycles; every DIV-th one moves the index by plain integer arithmetic.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            exp_t e;
            int   n;
            int   d;
            bit   w;
            bit   t;
            w = 1'b0;
            t = 1'b0;
            if (!rst_n) begin
                m_sel[i]  = 0;
                m_cnt[i]  = 0;
                m_pdir[i] = 1'b0;
                q[i].delete();
            end else if (load) begin
                m_sel[i]  = int'(load_val);
                m_cnt[i]  = 0;
                m_pdir[i] = dir;
            end else if (en) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == div_of(i)) begin
                    m_cnt[i] = 0;
                    t = 1'b1;
                    if (PPEN && pp) begin
                        d = m_pdir[i] ? -1 : 1;
                        n = m_sel[i] + d;
                        if (n > 7) begin
                            n = 6; m_pdir[i] = 1'b1; w = 1'b1;
                        end else if (n < 0) begin
                            n = 1; m_pdir[i] = 1'b0; w = 1'b1;
                        end
                    end else begin
                        d = dir ? -1 : 1;
                        n = m_sel[i] + d;
                        w = (n > 7) || (n < 0);
                        n = (n + 8) % 8;
                    end
                    m_sel[i] = n;
                end
            end
            e.sel  = 3'(m_sel[i]);
            e.tick = t;
            e.wrap = w;
            q[i].push_back(e);
        end
    end

    // Monitor: each falling clock edge pops one expectation per instance; a mid-cycle reset is checked at once.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (clk) begin
                    n_checks++;
                    if (sel_o[i] == 3'd0 && tick_o[i] == 1'b0 && wrap_o[i] == 1'b0) n_pass++;
                    else $display("FAIL async_reset[div%0d] got sel=%0d tick=%0b wrap=%0b need 0/0/0 at %0t",
                                  div_of(i), sel_o[i], tick_o[i], wrap_o[i], $time);
                end else begin
                    n_checks++;
                    if (q[i].size() == 0) begin
                        $display("FAIL scoreboard_empty[div%0d] got no expectation need one at %0t", div_of(i), $time);
                    end else begin
                        exp_t e;
                        e = q[i].pop_front();
                        if (sel_o[i] == e.sel && tick_o[i] == e.tick && wrap_o[i] == e.wrap) n_pass++;
                        else $display("FAIL seq[div%0d] got sel=%0d tick=%0b wrap=%0b need sel=%0d tick=%0b wrap=%0b at %0t",
                                      div_of(i), sel_o[i], tick_o[i], wrap_o[i], e.sel, e.tick, e.wrap, $time);
                    end
                end
            end
        end
    end

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input bit e_i, input bit d_i, input bit l_i, input logic [2:0] v_i, input bit p_i, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            en = e_i; dir = d_i; load = l_i; load_val = v_i; pp = p_i;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Free-running up count through several wraps.
        drive(1, 0, 0, 3'd0, 0, 30);
        // Reset in the middle of a count, then restart.
        async_reset();
        drive(1, 0, 0, 3'd0, 0, 12);
        // Load 2, then count down through the 0->7 wrap.
        drive(0, 0, 1, 3'd2, 0, 1);
        drive(1, 1, 0, 3'd0, 0, 20);
        // Enable gaps of five cycles.
        for (int r = 0; r < 6; r++) begin
            drive(1, 0, 0, 3'd0, 0, 2 + r);
            drive(0, 0, 0, 3'd0, 0, 5);
        end
        // Load while enabled, landing on assorted prescaler phases.
        for (int r = 0; r < 8; r++) begin
            drive(1, 0, 0, 3'd0, 0, r);
            drive(1, 0, 1, 3'd5, 0, 1);
        end
        // Ping-pong bounce from 5 going up.
        drive(0, 0, 1, 3'd5, 1, 1);
        drive(1, 0, 0, 3'd0, 1, 60);
        drive(1, 1, 0, 3'd0, 0, 10);
        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            @(negedge clk);
            en   = ($urandom_range(0, 5) != 0);
            load = ($urandom_range(0, 19) == 0);
            load_val = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 31) == 0) pp = ~pp;
        end
        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
